fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Program-counter sequencer for the IF stage of the 5-stage MIPS pipeline.
- Drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID register.
- Applies branch/jump redirects resolved in ID with MIPS one-instruction delay-slot semantics, including when a stall lands on the redirect cycle.

Parameters:
INST_NUM_BIT, 8, width of instruction-memory word address
INST_NUM, 47, number of populated instruction words (used by range check)
RESET_PC, 32'h0000_0000, byte PC loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall_i  in  1  hazard unit holds PC and IF/ID
redirect_valid_i  in  1  taken branch/jump resolved in ID this cycle
redirect_target_i  in  32  byte target of that branch/jump
inst_addr_o  out  INST_NUM_BIT  word address to instruction memory
inst_i  in  32  instruction returned combinationally for inst_addr_o
if_id_valid_o  out  1  IF/ID holds a real instruction
if_id_inst_o  out  32  IF/ID instruction
if_id_pc_o  out  32  IF/ID byte PC
if_id_pc8_o  out  32  IF/ID PC+8 (link value for jal/jalr)
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - pc=RESET_PC, state=RUN, pend_target=0.
  - if_id_valid_o=0, if_id_inst_o=0, if_id_pc_o=0, if_id_pc8_o=0.
- inst_addr_o = pc[INST_NUM_BIT+1:2], combinational from the pc register. Low 2 PC bits are ignored.
- IF/ID latency is one cycle. On each non-stalled edge, IF/ID <= {valid=1, inst_i, pc, pc+8}.
- When stall_i=1: pc, IF/ID and pend_target hold. Only the state changes listed below may occur.
- PC arithmetic is 32-bit and wraps modulo 2^32. There is no alignment trap.
- Delay slot: when redirect_valid_i is seen, the instruction at pc is the delay slot. The delay slot is always fetched and passed to ID, and is never flushed. The target is fetched next.
- FSM states:
  - RUN:
    - redirect_valid_i=1, stall_i=0: pc<=redirect_target_i; go to SLOT.
    - redirect_valid_i=1, stall_i=1: pend_target<=redirect_target_i; go to PEND; pc holds.
    - otherwise: pc<=pc+4 when not stalled.
  - PEND:
    - Ignore redirect_valid_i, because the same branch is still held in ID.
    - On the first cycle with stall_i=0: pc<=pend_target; go to SLOT.
  - SLOT (delay slot now in ID):
    - redirect_valid_i is ignored, so a branch in a delay slot is dropped.
    - If stall_i=0: pc<=pc+4; go to RUN. If stalled: stay in SLOT.
- Simultaneous stall and redirect are handled only through PEND; the redirect is never lost.
- Encoding: RUN=0, PEND=1, SLOT=2. Value 3 is unreachable and recovers to RUN.

Optional Feature:
FETCH_RANGE_CHECK_EN
- Defined:
  - If pc[INST_NUM_BIT+1:2] >= INST_NUM, IF/ID captures 32'h0000_0000 (nop) instead of inst_i, with valid=1.
  - Adds output oob_o (1 bit), registered, set with that IF/ID load, cleared on the next in-range non-stalled load, reset 0.
- Undefined: inst_i is captured unconditionally and oob_o is absent.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding constants FS_RUN, FS_PEND, FS_SLOT
  - NOP_INST = 32'h0
  - default RESET_PC
- One sub-module if_id_reg: the IF/ID pipeline register with hold and async active-low reset. It is shared with the later ID/EX register style.
- Next-PC selection and FSM stay in fetch_sequencer.

Test Plan:
1. Reset then free-run, no stall/redirect -> inst_addr_o steps 0,1,2,…; if_id_pc_o lags pc by one cycle; if_id_pc8_o = if_id_pc_o+8.
2. jal at 0x30 reaches ID while pc=0x34; pulse redirect_valid_i with target 0x40 -> next pc=0x40; 0x34 (delay slot) enters ID with valid=1; state SLOT then RUN.
3. Same redirect with stall_i=1 for 2 cycles -> state PEND; pc holds 0x34. After stall release, 0x34 goes to ID and pc=0x40, no fetch of 0x38.
4. Redirect asserted during SLOT (branch in delay slot, target 0x80) -> ignored; pc = 0x44 after 0x40.
5. Assert reset low mid-PEND -> all outputs 0, pc=RESET_PC, state RUN; after release, fetch restarts at word 0.
6. FETCH_RANGE_CHECK_EN, INST_NUM=47, pc reaches 0xBC (word 47) -> if_id_inst_o=0 and oob_o=1. Redirect to 0x00 -> oob_o clears after the next in-range load.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM state encoding,
// the nop instruction word and the default reset PC.
package fetch_pkg;

  // Fetch FSM state encoding; value 2'd3 is unused and recovers to FS_RUN.
  typedef enum logic [1:0] {
    FS_RUN  = 2'd0,
    FS_PEND = 2'd1,
    FS_SLOT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] LINK_OFFSET      = 32'd8;

endpackage

// File: rtl/fetch_sequencer_if_id_reg.sv
// IF/ID pipeline register: loads {valid, inst, pc, pc+8} when not held,
// keeps its contents while held, clears to zero on asynchronous reset.
module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc8_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc8_o
);

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] pc8_q;

  // Pipeline register with hold; reset empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
      pc8_q   <= 32'h0000_0000;
    end else if (!hold_i) begin
      valid_q <= valid_i;
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      pc8_q   <= pc8_i;
    end else begin
      valid_q <= valid_q;
      inst_q  <= inst_q;
      pc_q    <= pc_q;
      pc8_q   <= pc8_q;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign pc8_o   = pc8_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage program-counter sequencer for the 5-stage MIPS pipeline.
// Applies ID-resolved redirects with one-instruction delay-slot semantics;
// a redirect that coincides with a stall is parked in PEND until released.
// Optional feature macro: FETCH_RANGE_CHECK_EN (out-of-range fetches load a
// nop into IF/ID and raise oob_o).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          INST_NUM_BIT = 8,
  parameter int          INST_NUM     = 47,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    redirect_valid_i,
  input  logic [31:0]             redirect_target_i,
  output logic [INST_NUM_BIT-1:0] inst_addr_o,
  input  logic [31:0]             inst_i,
  output logic                    if_id_valid_o,
  output logic [31:0]             if_id_inst_o,
  output logic [31:0]             if_id_pc_o,
  output logic [31:0]             if_id_pc8_o,
  output logic [1:0]              state_o
`ifdef FETCH_RANGE_CHECK_EN
  ,
  output logic                    oob_o
`endif
);

  localparam logic [31:0] INST_NUM_W = INST_NUM;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  inst_cap_s;
  logic [31:0]  addr_ext_s;

  assign inst_addr_o = pc_q[INST_NUM_BIT+1:2];
  assign addr_ext_s  = {{(32-INST_NUM_BIT){1'b0}}, pc_q[INST_NUM_BIT+1:2]};

  // PC, pending redirect target and FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Next-PC selection and FSM transitions; the delay slot at pc is always
  // fetched before the redirect target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      FS_RUN: begin
        if (redirect_valid_i && !stall_i) begin
          pc_d    = redirect_target_i;
          state_d = FS_SLOT;
        end else if (redirect_valid_i && stall_i) begin
          pend_d  = redirect_target_i;
          state_d = FS_PEND;
        end else if (!stall_i) begin
          pc_d = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      FS_PEND: begin
        // The branch is still sitting in ID; its repeat request is ignored.
        if (!stall_i) begin
          pc_d    = pend_q;
          state_d = FS_SLOT;
        end else begin
          state_d = FS_PEND;
        end
      end
      FS_SLOT: begin
        // A branch in the delay slot is dropped.
        if (!stall_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = FS_RUN;
        end else begin
          state_d = FS_SLOT;
        end
      end
      default: begin
        state_d = FS_RUN;
      end
    endcase
  end

`ifdef FETCH_RANGE_CHECK_EN
  logic oob_s;
  logic oob_q;

  assign oob_s = (addr_ext_s >= INST_NUM_W);

  // Substitute a nop for fetches beyond the populated instruction words.
  always_comb begin
    inst_cap_s = inst_i;
    if (oob_s) begin
      inst_cap_s = NOP_INST;
    end else begin
      inst_cap_s = inst_i;
    end
  end

  // Out-of-range flag travels with the IF/ID load it describes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_q <= 1'b0;
    end else if (!stall_i) begin
      oob_q <= oob_s;
    end else begin
      oob_q <= oob_q;
    end
  end

  assign oob_o = oob_q;
`else
  logic range_unused_s;

  assign inst_cap_s     = inst_i;
  assign range_unused_s = (addr_ext_s == INST_NUM_W);
`endif

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (reset),
    .hold_i  (stall_i),
    .valid_i (1'b1),
    .inst_i  (inst_cap_s),
    .pc_i    (pc_q),
    .pc8_i   (pc_q + LINK_OFFSET),
    .valid_o (if_id_valid_o),
    .inst_o  (if_id_inst_o),
    .pc_o    (if_id_pc_o),
    .pc8_o   (if_id_pc8_o)
  );

  assign state_o = state_q;

endmodule
